// File: rtl/reg_readback_pkg.sv
// Shared definitions for the tri-state register readback scanner:
// state encoding and parameter legality checks.
package reg_readback_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_GAP    = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_OUTPUT = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_GAP    = ST_GAP,
    S_SETTLE = ST_SETTLE,
    S_OUTPUT = ST_OUTPUT,
    S_DONE   = ST_DONE
  } state_e;

  function automatic bit params_ok(
    input int nregs,
    input int width,
    input int settle
  );
    return (nregs >= 2) && (width >= 1) &&
           (settle >= 1);
  endfunction

endpackage

// File: rtl/reg_readback_scanner_if.sv
// Byte stream from the scanner to its consumer:
// data, slot index and a valid/ready handshake.
interface reg_readback_scanner_if #(
  parameter int WIDTH = 8,
  parameter int IW    = 3
) ();

  logic [WIDTH-1:0] dout;
  logic [IW-1:0]    dout_idx;
  logic             dout_valid;
  logic             dout_ready;

  modport master (
    output dout,
    output dout_idx,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_idx,
    input  dout_valid,
    output dout_ready
  );

endinterface

// File: rtl/reg_readback_scanner.sv
// Scans a bank of tri-state registers one slot at a time with
// break-before-make on the shared bus, streaming each byte out.
module reg_readback_scanner
  import reg_readback_pkg::*;
#(
  parameter int NREGS  = 8,
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2,
  parameter int IW     = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] bus_in,
  output logic [NREGS-1:0] noe,
  output logic             busy,
  output logic             done,
  reg_readback_scanner_if.master out_if
);

  if (!params_ok(NREGS, WIDTH, SETTLE)) begin : g_bad
    $error("reg_readback_scanner: bad parameters");
  end

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(SETTLE - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(NREGS - 1);
  localparam logic [NREGS-1:0] ONE_HOT0 =
    NREGS'(1);
  localparam logic [NREGS-1:0] ALL_OFF = '1;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NREGS-1:0] noe_q, noe_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [IW-1:0]    didx_q, didx_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      noe_q   <= ALL_OFF;
      dout_q  <= '0;
      didx_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      noe_q   <= noe_d;
      dout_q  <= dout_d;
      didx_q  <= didx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    noe_d   = noe_q;
    dout_d  = dout_q;
    didx_d  = didx_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        cnt_d   = '0;
        noe_d   = ~(ONE_HOT0 << idx_q);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          dout_d  = bus_in;
          didx_d  = idx_q;
          valid_d = 1'b1;
          noe_d   = ALL_OFF;
          state_d = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (valid_q && out_if.dout_ready) begin
          valid_d = 1'b0;
          if (idx_q == IDX_LAST) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_GAP;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        noe_d   = ALL_OFF;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Cancel wins over any handshake on the same edge.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      noe_d   = ALL_OFF;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  assign noe               = noe_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign out_if.dout       = dout_q;
  assign out_if.dout_idx   = didx_q;
  assign out_if.dout_valid = valid_q;

endmodule

// File: tb/tb_reg_readback_scanner.sv
// Directed bench for reg_readback_scanner with a bank of
// tri-state 574-style registers on a shared bus.
module tb_reg_readback_scanner;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  wire  [7:0] bus;
  logic [7:0] noe;
  logic       busy;
  logic       done;
  logic [7:0] regs [N];

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  logic [7:0] prev_noe = 8'hFF;

  reg_readback_scanner_if #(.WIDTH(8), .IW(3)) u_if ();

  reg_readback_scanner #(
    .NREGS(N), .WIDTH(8), .SETTLE(2), .IW(3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .abort  (abort),
    .bus_in (bus),
    .noe    (noe),
    .busy   (busy),
    .done   (done),
    .out_if (u_if)
  );

  for (genvar g = 0; g < N; g++) begin : g_ff574
    assign bus = noe[g] ? 8'hzz : regs[g];
  end

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Bus contention and break-before-make monitor.
  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      if ($countones(~noe) > 1) begin
        n_bad++;
        $display("FAIL contention: noe=%h", noe);
      end
      n_cmp++;
      if (noe != 8'hFF && prev_noe != 8'hFF &&
          noe != prev_noe) begin
        n_bad++;
        $display("FAIL no_gap: noe %h -> %h",
                 prev_noe, noe);
      end
      if (noe != 8'hFF) begin
        n_cmp++;
        if ($isunknown(bus)) begin
          n_bad++;
          $display("FAIL bus_x: bus=%h", bus);
        end
      end
      prev_noe = noe;
    end
  end

  task automatic preload();
    for (int i = 0; i < N; i++)
      regs[i] = 8'(17 * i);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({noe, u_if.dout, u_if.dout_idx,
         u_if.dout_valid, busy, done} !==
        {8'hFF, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_vals: noe=%h d=%h i=%0d v=%b b=%b dn=%b",
               noe, u_if.dout, u_if.dout_idx,
               u_if.dout_valid, busy, done);
    end
  endtask

  task automatic test_basic_scan();
    int hs_k[$];
    logic [7:0] hs_d[$];
    int hs_i[$];
    int ndone = 0;
    int done_k = -1;
    preload();
    u_if.dout_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_bad++;
          $display("FAIL basic_busy0: got %b want 1", busy);
        end
      end
      if (k == 1) begin
        n_cmp++;
        if (noe !== 8'hFE) begin
          n_bad++;
          $display("FAIL basic_noe0: got %h want fe", noe);
        end
      end
      if (u_if.dout_valid && u_if.dout_ready) begin
        hs_k.push_back(k);
        hs_d.push_back(u_if.dout);
        hs_i.push_back(int'(u_if.dout_idx));
      end
      if (done) begin
        ndone++;
        done_k = k;
      end
      if (k == 33) begin
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          n_bad++;
          $display("FAIL basic_end: busy=%b done=%b want 0 0",
                   busy, done);
        end
      end
    end
    n_cmp++;
    if (hs_k.size() != 8) begin
      n_bad++;
      $display("FAIL basic_count: got %0d want 8",
               hs_k.size());
    end
    foreach (hs_k[j]) begin
      n_cmp++;
      if (hs_d[j] !== 8'(17 * j) || hs_i[j] != j ||
          hs_k[j] != 3 + 4 * j) begin
        n_bad++;
        $display("FAIL basic_byte%0d: d=%h i=%0d k=%0d want %h %0d %0d",
                 j, hs_d[j], hs_i[j], hs_k[j],
                 8'(17 * j), j, 3 + 4 * j);
      end
    end
    n_cmp++;
    if (ndone != 1 || done_k != 32) begin
      n_bad++;
      $display("FAIL basic_done: n=%0d k=%0d want 1 32",
               ndone, done_k);
    end
  endtask

  task automatic test_backpressure();
    int hs_k[$];
    logic [7:0] hs_d[$];
    int hs_i[$];
    int ndone = 0;
    int stall = 0;
    preload();
    u_if.dout_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (u_if.dout_valid && u_if.dout_idx == 3'd3 &&
          stall < 5) begin
        n_cmp++;
        if (u_if.dout !== 8'h33 || noe !== 8'hFF) begin
          n_bad++;
          $display("FAIL bp_hold%0d: d=%h noe=%h want 33 ff",
                   stall, u_if.dout, noe);
        end
        u_if.dout_ready = 1'b0;
        stall++;
      end else begin
        u_if.dout_ready = 1'b1;
      end
      if (u_if.dout_valid && u_if.dout_ready) begin
        hs_k.push_back(k);
        hs_d.push_back(u_if.dout);
        hs_i.push_back(int'(u_if.dout_idx));
      end
      if (done) ndone++;
    end
    n_cmp++;
    if (hs_k.size() != 8 || stall != 5 || ndone != 1) begin
      n_bad++;
      $display("FAIL bp_count: hs=%0d stall=%0d done=%0d want 8 5 1",
               hs_k.size(), stall, ndone);
    end
    foreach (hs_k[j]) begin
      n_cmp++;
      if (hs_d[j] !== 8'(17 * j) || hs_i[j] != j) begin
        n_bad++;
        $display("FAIL bp_byte%0d: d=%h i=%0d want %h %0d",
                 j, hs_d[j], hs_i[j], 8'(17 * j), j);
      end
    end
    if (hs_k.size() >= 5) begin
      n_cmp++;
      if (hs_k[3] != 20 || hs_k[4] != 24) begin
        n_bad++;
        $display("FAIL bp_timing: k3=%0d k4=%0d want 20 24",
                 hs_k[3], hs_k[4]);
      end
    end
  endtask

  task automatic test_abort();
    bit found = 1'b0;
    int ndone = 0;
    int first_k = -1;
    logic [7:0] first_d = 8'h00;
    int first_i = -1;
    preload();
    u_if.dout_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (noe == 8'hDF) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL abort_wait: slot 5 not reached, noe=%h", noe);
    end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({noe, u_if.dout_valid, busy, done} !==
        {8'hFF, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL abort_state: noe=%h v=%b b=%b dn=%b want ff 0 0 0",
               noe, u_if.dout_valid, busy, done);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    n_cmp++;
    if (ndone != 0) begin
      n_bad++;
      $display("FAIL abort_quiet: active cycles=%0d want 0", ndone);
    end
    pulse_start();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (u_if.dout_valid && first_k < 0) begin
        first_k = k;
        first_d = u_if.dout;
        first_i = int'(u_if.dout_idx);
      end
    end
    n_cmp++;
    if (first_k != 3 || first_i != 0 || first_d !== 8'h00) begin
      n_bad++;
      $display("FAIL abort_restart: k=%0d i=%0d d=%h want 3 0 00",
               first_k, first_i, first_d);
    end
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    n_cmp++;
    if (ndone != 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_rescan: done=%0d busy=%b want 1 0",
               ndone, busy);
    end
  endtask

  task automatic test_reset_mid_output();
    bit found = 1'b0;
    preload();
    regs[0] = 8'hA5;
    u_if.dout_ready = 1'b0;
    pulse_start();
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (u_if.dout_valid) found = 1'b1;
    end
    n_cmp++;
    if (!found || u_if.dout !== 8'hA5) begin
      n_bad++;
      $display("FAIL rst_pre: found=%b d=%h want 1 a5",
               found, u_if.dout);
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({noe, u_if.dout, u_if.dout_idx,
         u_if.dout_valid, busy, done} !==
        {8'hFF, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL rst_mid: noe=%h d=%h i=%0d v=%b b=%b dn=%b",
               noe, u_if.dout, u_if.dout_idx,
               u_if.dout_valid, busy, done);
    end
    u_if.dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || noe !== 8'hFF) begin
      n_bad++;
      $display("FAIL rst_idle: busy=%b noe=%h want 0 ff",
               busy, noe);
    end
  endtask

  task automatic test_ignored_start();
    int nhs = 0;
    int ndone = 0;
    preload();
    u_if.dout_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (u_if.dout_valid && u_if.dout_ready) nhs++;
      if (done) ndone++;
      if (k == 10 || k == 32) start = 1'b1;
      if (k == 11 || k == 33) start = 1'b0;
      if (k == 32) begin
        n_cmp++;
        if (done !== 1'b1) begin
          n_bad++;
          $display("FAIL ign_in_done: done=%b want 1", done);
        end
      end
    end
    n_cmp++;
    if (nhs != 8 || ndone != 1 || busy !== 1'b0 ||
        noe !== 8'hFF) begin
      n_bad++;
      $display("FAIL ign_start: hs=%0d done=%0d b=%b noe=%h want 8 1 0 ff",
               nhs, ndone, busy, noe);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    u_if.dout_ready = 1'b0;
    preload();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;
    test_reset();
    test_basic_scan();
    repeat (3) @(negedge clk);
    test_backpressure();
    repeat (3) @(negedge clk);
    test_abort();
    repeat (3) @(negedge clk);
    test_reset_mid_output();
    repeat (3) @(negedge clk);
    test_ignored_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
